// File: rtl/datapath_ctrl.sv
// Three-state sequencer (IDLE/EXEC/WB) driving the regfile/ALU datapath.
// Latches one micro-instruction per handshake and owns the architectural flags.
module datapath_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [10:0]      instr,
  output logic             instr_ready,
  input  logic             clr_ovf,
  input  logic             Zero,
  input  logic             Overflow,
  output logic             wr,
  output logic [2:0]       ALUControl,
  output logic [1:0]       addr1,
  output logic [1:0]       addr2,
  output logic [1:0]       addr3,
  output logic             z_flag,
  output logic             v_flag,
  output logic             ovf_sticky,
  output logic             done,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [1:0]       a1_q, a2_q, a3_q;
  logic             wb_en_q, wb_en_d;
  logic             wr_q, done_q;
  logic             z_q, v_q, s_q;
  logic [CNT_W-1:0] ret_q;
  logic             accept;

  assign instr_ready = (state_q == IDLE) && rst;
  assign accept      = instr_ready && instr_valid;

  // Gate decision uses the flags from before this instruction.
  always_comb begin
    wb_en_d = 1'b0;
    unique case (instr[10:9])
      2'b00:   wb_en_d = 1'b1;
      2'b01:   wb_en_d = z_q;
      2'b10:   wb_en_d = ~z_q;
      default: wb_en_d = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      a3_q    <= '0;
      wb_en_q <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      s_q     <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= instr[8:6];
        a3_q    <= instr[5:4];
        a1_q    <= instr[3:2];
        a2_q    <= instr[1:0];
        wb_en_q <= wb_en_d;
      end
      wr_q   <= (state_q == EXEC) && wb_en_q;
      done_q <= (state_q == EXEC);
      if (state_q == EXEC) begin
        z_q <= Zero;
        v_q <= Overflow;
      end
      // A capture in the same cycle as a clear keeps the sticky bit set.
      if ((state_q == EXEC) && Overflow)
        s_q <= 1'b1;
      else if (clr_ovf)
        s_q <= 1'b0;
      if (state_q == WB)
        ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign wr         = wr_q;
  assign done       = done_q;
  assign ALUControl = op_q;
  assign addr1      = a1_q;
  assign addr2      = a2_q;
  assign addr3      = a3_q;
  assign z_flag     = z_q;
  assign v_flag     = v_q;
  assign ovf_sticky = s_q;
  assign retired    = ret_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench for datapath_ctrl: driver pushes model results,
// a negedge monitor pops them on every done pulse.
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic [10:0] instr = '0;
  logic        instr_ready;
  logic        clr_ovf = 1'b0;
  logic        Zero = 1'b0;
  logic        Overflow = 1'b0;
  logic        wr;
  logic [2:0]  ALUControl;
  logic [1:0]  addr1, addr2, addr3;
  logic        z_flag, v_flag, ovf_sticky, done;
  logic [7:0]  retired;

  datapath_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .clr_ovf(clr_ovf),
    .Zero(Zero), .Overflow(Overflow),
    .wr(wr), .ALUControl(ALUControl),
    .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .z_flag(z_flag), .v_flag(v_flag),
    .ovf_sticky(ovf_sticky), .done(done),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [2:0] op;
    logic [1:0] a1, a2, a3;
    logic       z, v, s;
    logic [7:0] ret;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_push = 0;
  int   n_done = 0;
  bit   mon_en = 1'b0;

  bit       m_z, m_v, m_s;
  int       m_ret;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one instruction's architectural effect, in program order.
  task automatic model(input logic [10:0] ins, input bit zr, input bit ov,
                       input bit clr_a, input bit clr_e);
    exp_t e;
    bit   wb;
    if (clr_a) m_s = 1'b0;
    case (ins[10:9])
      2'b00:   wb = 1'b1;
      2'b01:   wb = m_z;
      2'b10:   wb = !m_z;
      default: wb = 1'b0;
    endcase
    m_z = zr;
    m_v = ov;
    if (ov) m_s = 1'b1;
    else if (clr_e) m_s = 1'b0;
    e.wr = wb;
    e.op = ins[8:6];
    e.a3 = ins[5:4];
    e.a1 = ins[3:2];
    e.a2 = ins[1:0];
    e.z = m_z;
    e.v = m_v;
    e.s = m_s;
    e.ret = 8'(m_ret);
    q.push_back(e);
    n_push++;
    m_ret = (m_ret + 1) % 256;
  endtask

  task automatic issue(input logic [10:0] ins, input bit zr, input bit ov,
                       input bit clr_a, input bit clr_e, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    chk("ready_idle", instr_ready, 1);
    instr_valid = 1'b1;
    instr = ins;
    Zero = zr;
    Overflow = ov;
    clr_ovf = clr_a;
    model(ins, zr, ov, clr_a, clr_e);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 11'($urandom);
    clr_ovf = clr_e;
    chk("exec_ready", instr_ready, 0);
    chk("exec_wr", wr, 0);
    chk("exec_done", done, 0);
    chk("exec_addr1", addr1, ins[3:2]);
    chk("exec_addr2", addr2, ins[1:0]);
    chk("exec_addr3", addr3, ins[5:4]);
    chk("exec_op", ALUControl, ins[8:6]);
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    Zero = 1'($urandom);
    Overflow = 1'($urandom);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("wr_implies_done", wr & ~done, 0);
      if (done) begin
        n_done++;
        chk("ready_in_wb", instr_ready, 0);
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("wb_wr", wr, e.wr);
          chk("wb_op", ALUControl, e.op);
          chk("wb_addr1", addr1, e.a1);
          chk("wb_addr2", addr2, e.a2);
          chk("wb_addr3", addr3, e.a3);
          chk("z_flag", z_flag, e.z);
          chk("v_flag", v_flag, e.v);
          chk("ovf_sticky", ovf_sticky, e.s);
          chk("retired", retired, e.ret);
        end
      end
    end
  end

  initial begin
    logic [10:0] base;
    int          n_acc;
    base = 11'b00_010_11_01_10;
    #2;
    chk("ready_in_reset", instr_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_wr", wr, 0);
    chk("rst_done", done, 0);
    chk("rst_op", ALUControl, 0);
    chk("rst_addr1", addr1, 0);
    chk("rst_addr2", addr2, 0);
    chk("rst_addr3", addr3, 0);
    chk("rst_z", z_flag, 0);
    chk("rst_v", v_flag, 0);
    chk("rst_sticky", ovf_sticky, 0);
    chk("rst_retired", retired, 0);

    // Reset in the middle of write-back.
    instr_valid = 1'b1;
    instr = base;
    Overflow = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("midwb_wr_before", wr, 1);
    chk("midwb_done_before", done, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("midwb_wr_async", wr, 0);
    chk("midwb_done_async", done, 0);
    chk("midwb_ready", instr_ready, 0);
    chk("midwb_retired", retired, 0);
    chk("midwb_sticky", ovf_sticky, 0);
    @(negedge clk);
    rst = 1'b1;
    Overflow = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_retired", retired, 0);
    chk("post_rst_wr", wr, 0);

    m_z = 0; m_v = 0; m_s = 0; m_ret = 0;
    mon_en = 1'b1;

    // ALWAYS, CMP, IFZ, IFNZ
    issue(base, 0, 0, 0, 0, 0);
    issue(11'b11_110_00_01_10, 1, 0, 0, 0, 1);
    issue(11'b01_000_10_11_00, 0, 0, 0, 0, 0);
    issue(11'b10_001_01_10_11, 1, 0, 0, 0, 0);
    issue(11'b01_001_01_10_11, 0, 0, 0, 0, 0);
    // Sticky overflow
    issue(11'b00_010_01_00_01, 0, 1, 0, 0, 0);
    issue(11'b00_011_10_00_01, 0, 0, 0, 0, 0);
    issue(11'b00_100_11_00_01, 0, 0, 1, 0, 2);
    issue(11'b00_101_00_00_01, 0, 1, 0, 1, 0);
    issue(11'b00_101_00_00_01, 0, 0, 0, 1, 0);

    // Back-to-back: valid held for 9 cycles.
    @(negedge clk);
    instr_valid = 1'b1;
    instr = base;
    Zero = 1'b1;
    Overflow = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 9; i++) begin
      if (instr_ready) begin
        n_acc++;
        chk("b2b_slot", i % 3, 0);
        model(base, 1, 0, 0, 0);
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("b2b_accepts", n_acc, 3);

    // Random run long enough to wrap the counter.
    for (int i = 0; i < 300; i++) begin
      issue(11'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2));
    end

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("done_count", n_done, n_push);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
